// File: rtl/range_residual_checker.sv
`default_nettype none
// ============================================================================
// Module      : range_residual_checker
// Description : Per-anchor residuals |p-a_k|^2 - r_k^2 on one shared squarer.
// Revision    : 1.0 - initial release
// ============================================================================
module range_residual_checker #(
    parameter int               W   = 32,
    parameter logic [2*W+1:0]   TOL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     px,
    input  logic [W-1:0]     py,
    input  logic [W-1:0]     pz,
    input  logic [W-1:0]     x1,
    input  logic [W-1:0]     x2,
    input  logic [W-1:0]     x3,
    input  logic [W-1:0]     x4,
    input  logic [W-1:0]     y1,
    input  logic [W-1:0]     y2,
    input  logic [W-1:0]     y3,
    input  logic [W-1:0]     y4,
    input  logic [W-1:0]     z1,
    input  logic [W-1:0]     z2,
    input  logic [W-1:0]     z3,
    input  logic [W-1:0]     z4,
    input  logic [W-1:0]     r1,
    input  logic [W-1:0]     r2,
    input  logic [W-1:0]     r3,
    input  logic [W-1:0]     r4,
    output logic             busy,
    output logic             done,
    output logic [2*W+2:0]   res1,
    output logic [2*W+2:0]   res2,
    output logic [2*W+2:0]   res3,
    output logic [2*W+2:0]   res4,
    output logic             pass
);

    localparam int c_ACC_W = 2*W + 3;

    typedef enum logic [2:0] {
        S_IDLE, S_DIFF, S_SQX, S_SQY, S_SQZ, S_SQR, S_DONE
    } state_t;

    state_t               r_state, w_next;
    logic [W-1:0]         r_px, r_py, r_pz;
    logic [W-1:0]         r_ax [4];
    logic [W-1:0]         r_ay [4];
    logic [W-1:0]         r_az [4];
    logic [W-1:0]         r_rng [4];
    logic [1:0]           r_k;
    logic [W:0]           r_dx, r_dy, r_dz;
    logic [c_ACC_W-1:0]   r_acc;
    logic [c_ACC_W-1:0]   r_res [4];
    logic [3:0]           r_flag;
    logic                 r_pass;

    logic [W:0]           w_mul_a;
    logic [2*W+1:0]       w_mul_ext;
    logic [2*W+1:0]       w_prod;
    logic [c_ACC_W-1:0]   w_sq, w_res, w_abs;
    logic                 w_flag;
    logic [W:0]           w_dx, w_dy, w_dz;

    // Every multiplier use is a square; only the low 2W+2 product bits matter,
    // so sign-extending the operand yields the signed square directly.
    always_comb begin
        w_mul_a = '0;
        case (r_state)
            S_SQX:   w_mul_a = r_dx;
            S_SQY:   w_mul_a = r_dy;
            S_SQZ:   w_mul_a = r_dz;
            S_SQR:   w_mul_a = {1'b0, r_rng[r_k]};
            default: w_mul_a = '0;
        endcase
    end

    assign w_mul_ext = {{(W+1){w_mul_a[W]}}, w_mul_a};
    assign w_prod    = w_mul_ext * w_mul_ext;
    assign w_sq      = {1'b0, w_prod};
    assign w_res     = r_acc - w_sq;
    assign w_abs     = w_res[c_ACC_W-1] ? (~w_res + 1'b1) : w_res;
    assign w_flag    = (w_abs <= {1'b0, TOL});

    assign w_dx = {r_ax[r_k][W-1], r_ax[r_k]} - {r_px[W-1], r_px};
    assign w_dy = {r_ay[r_k][W-1], r_ay[r_k]} - {r_py[W-1], r_py};
    assign w_dz = {r_az[r_k][W-1], r_az[r_k]} - {r_pz[W-1], r_pz};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = S_DIFF;
            S_DIFF: begin busy = 1'b1; w_next = S_SQX; end
            S_SQX:  begin busy = 1'b1; w_next = S_SQY; end
            S_SQY:  begin busy = 1'b1; w_next = S_SQZ; end
            S_SQZ:  begin busy = 1'b1; w_next = S_SQR; end
            S_SQR:  begin
                busy   = 1'b1;
                w_next = (r_k == 2'd3) ? S_DONE : S_DIFF;
            end
            S_DONE: begin done = 1'b1; w_next = S_IDLE; end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_px   <= '0;
            r_py   <= '0;
            r_pz   <= '0;
            r_k    <= '0;
            r_dx   <= '0;
            r_dy   <= '0;
            r_dz   <= '0;
            r_acc  <= '0;
            r_flag <= '0;
            r_pass <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_ax[i]  <= '0;
                r_ay[i]  <= '0;
                r_az[i]  <= '0;
                r_rng[i] <= '0;
                r_res[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_px  <= px;
                    r_py  <= py;
                    r_pz  <= pz;
                    r_ax[0] <= x1; r_ax[1] <= x2; r_ax[2] <= x3; r_ax[3] <= x4;
                    r_ay[0] <= y1; r_ay[1] <= y2; r_ay[2] <= y3; r_ay[3] <= y4;
                    r_az[0] <= z1; r_az[1] <= z2; r_az[2] <= z3; r_az[3] <= z4;
                    r_rng[0] <= r1; r_rng[1] <= r2; r_rng[2] <= r3; r_rng[3] <= r4;
                    r_k   <= '0;
                end
                S_DIFF: begin
                    r_dx <= w_dx;
                    r_dy <= w_dy;
                    r_dz <= w_dz;
                end
                S_SQX:  r_acc <= w_sq;
                S_SQY:  r_acc <= r_acc + w_sq;
                S_SQZ:  r_acc <= r_acc + w_sq;
                S_SQR: begin
                    r_res[r_k]  <= w_res;
                    r_flag[r_k] <= w_flag;
                    // Flag 3 is registered on this same edge, so use it live.
                    if (r_k == 2'd3) begin
                        r_pass <= w_flag & (&r_flag[2:0]);
                    end else begin
                        r_k <= r_k + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res1 = r_res[0];
    assign res2 = r_res[1];
    assign res3 = r_res[2];
    assign res4 = r_res[3];
    assign pass = r_pass;

endmodule
`default_nettype wire

// File: doc/range_residual_checker.md
Name: range_residual_checker

Overview:
- Forward model for the trilateration linear solver: takes a solved position (px,py,pz) and the four anchor positions and measured ranges.
- For each anchor k it computes the residual: squared Euclidean distance minus the squared measured range.
- It flags whether every residual lies within a tolerance.
- It sits downstream of linear_solver as the consistency check on its result. One shared multiplier, sequenced by an FSM.

Parameters:
- W, 32: width of signed coordinates and unsigned ranges.
- TOL, 0: unsigned residual tolerance, width 2W+2; an anchor passes when |res| <= TOL.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a check; sampled only in IDLE
- px,py,pz  input  W each  solved position, signed two's complement
- x1,x2,x3,x4,y1,y2,y3,y4,z1,z2,z3,z4  input  W each  anchor coordinates, signed
- r1,r2,r3,r4  input  W each  measured ranges, unsigned
- busy  output  1  run in progress
- done  output  1  one-cycle pulse; results valid
- res1,res2,res3,res4  output  2W+3 each  signed residuals, held until next run
- pass  output  1  all four |res_k| <= TOL; valid with done, then held

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0; done=0; pass=0; res1..res4=0.
  - Internal accumulator, differences and anchor index are cleared.
  - Reset mid-run aborts immediately; no done pulse follows.
- States: IDLE, DIFF, SQX, SQY, SQZ, SQR, DONE. Anchor index k runs 0..3.
- IDLE:
  - With start=1 at edge N, all 19 inputs are captured into internal registers, k=0, state goes to DIFF, and busy=1.
  - Input changes after edge N have no effect on the run.
- DIFF: at the edge, dx=ax_k-px, dy=ay_k-py, dz=az_k-pz are registered, sign-extended to W+1 bits. Go to SQX.
- SQX: acc=dx*dx; go to SQY.
- SQY: acc=acc+dy*dy; go to SQZ.
- SQZ: acc=acc+dz*dz; go to SQR.
- SQR:
  - res_k = acc - r_k*r_k, registered; the per-anchor flag_k = (|res_k| <= TOL) is registered.
  - If k<3: k=k+1, go to DIFF. If k=3: go to DONE, set busy=0 and done=1, and register pass = AND of all four flags.
- DONE: lasts one cycle; done=1. Next edge returns to IDLE with done=0. start is ignored during DONE.
- Latency:
  - Residual k is registered at edge N+5(k+1).
  - done is high during the cycle following edge N+20.
  - busy is high from edge N to edge N+20.
  - With start held at 1, runs repeat back-to-back with a 22-cycle period.
- Multiplier: one signed (W+1)x(W+1) multiply per cycle. r_k is zero-extended to W+1 bits and shares the same multiplier.
- Widths:
  - Each square is at most 2^(2W+2) in magnitude.
  - acc is 2W+3 bits unsigned-valued; the sum of three squares cannot overflow.
  - res is 2W+3 bits signed and the full-range difference cannot overflow.
  - |res| comparison uses 2W+3 bits.
- start is ignored while busy=1.
- res1..res4 update progressively during a run. Consumers use them only at done or after.

Test Plan:
- Exact fit:
  - Stimulus: W=16, TOL=0, p=(0,0,0), anchors (3,4,0), (0,0,5), (6,8,0), (-5,0,0), r=5,5,10,5.
  - Response: res1..res4=0, pass=1, done exactly 21 cycles after the start-sampling edge (one pulse), busy high for 20 cycles.
- Mismatch:
  - Stimulus: same as exact fit but r1=6.
  - Response with TOL=0: res1=-11, others 0, pass=0. Response with TOL=11: pass=1. Response with TOL=10: pass=0.
- Extremes:
  - Stimulus: W=16, p=(-32768,-32768,-32768), anchor1=(32767,32767,32767), r1=65535; other anchors equal p with r=0.
  - Response: res1 = 3*4294836225 - 4294836225 = 8589672450, res2..res4=0, no overflow.
- Input isolation and busy lockout:
  - Stimulus: change all inputs and pulse start during cycles 3..15 of a run.
  - Response: results match the captured values, and the second start is not acted on.
- Reset mid-run:
  - Stimulus: assert rst asynchronously at cycle 12.
  - Response: outputs go to 0 immediately, with no done pulse. A fresh start after reset release completes normally in 21 cycles.
- Back-to-back:
  - Stimulus: start held at 1 for 50 cycles.
  - Response: done pulses 22 cycles apart, results identical each run.
